// File: rtl/hilo_md_unit_pkg.sv
// HI/LO multiply/divide shared definitions: command codes, default latencies, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hilo_md_unit_pkg;

  // Command codes; the E-stage decoder emits these same encodings.
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b111;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/hilo_md_unit_calc.sv
// hilo_calc: combinational {hi,lo} result for MULT/MULTU/DIV/DIVU incl. div-by-zero and overflow.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; result is valid whenever inputs are stable.
// Ports: op (command code), rs/rt (operands), res ({hi,lo} 64-bit result, 0 for non mul/div codes).
module hilo_calc
  import hilo_md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] res
);

  logic               rt_zero;
  logic               sdiv_ovf;
  logic signed [63:0] s_rs_ext;
  logic signed [63:0] s_rt_ext;
  logic signed [31:0] s_rt_safe;
  logic        [31:0] u_rt_safe;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;
  logic        [31:0] u_quo;
  logic        [31:0] u_rem;

  assign rt_zero  = (rt == 32'h0);
  assign sdiv_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

  assign s_rs_ext = $signed({{32{rs[31]}}, rs});
  assign s_rt_ext = $signed({{32{rt[31]}}, rt});

  // Substitute a harmless divisor on the special cases so the dividers never
  // see /0 or the one overflowing signed pair; those cases are muxed out below.
  assign s_rt_safe = (rt_zero || sdiv_ovf) ? 32'sd1 : $signed(rt);
  assign u_rt_safe = rt_zero ? 32'd1 : rt;

  // Verilog signed / and % truncate toward zero; remainder follows the dividend.
  assign s_quo = $signed(rs) / s_rt_safe;
  assign s_rem = $signed(rs) % s_rt_safe;
  assign u_quo = rs / u_rt_safe;
  assign u_rem = rs % u_rt_safe;

  always_comb begin
    res = 64'h0;
    case (op)
      OP_MULT:  res = s_rs_ext * s_rt_ext;
      OP_MULTU: res = {32'h0, rs} * {32'h0, rt};
      OP_DIV: begin
        if (rt_zero)       res = {rs, 32'hFFFF_FFFF};
        else if (sdiv_ovf) res = {32'h0, 32'h8000_0000};
        else               res = {s_rem, s_quo};
      end
      OP_DIVU: begin
        if (rt_zero) res = {rs, 32'hFFFF_FFFF};
        else         res = {u_rem, u_quo};
      end
      default:  res = 64'h0;
    endcase
  end

endmodule

// File: rtl/hilo_md_unit.sv
// E-stage HI/LO unit: multi-cycle MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, architectural HI/LO.
// Latency: mul/div results land MULT_CYCLES/DIV_CYCLES edges after accept; MTHI/MTLO visible after the accept edge.
// Backpressure: stall_req freezes the pipeline while busy or while a mul/div is being presented; commands while busy are ignored.
// Ports: clk, rst_n (async active-low); hilo_op/hilo_we command, flush kills it; rs_data/rt_data operands;
//        busy, stall_req (combinational) to hazard unit; hi/lo architectural registers.
module hilo_md_unit
  import hilo_md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  hilo_op,
  input  logic        hilo_we,
  input  logic        flush,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       p_hi_q, p_hi_d;
  logic [31:0]       p_lo_q, p_lo_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [63:0]       calc_res;
  logic              accept;

  hilo_calc u_calc (
    .op  (hilo_op),
    .rs  (rs_data),
    .rt  (rt_data),
    .res (calc_res)
  );

  assign busy      = (state_q == ST_RUN);
  assign accept    = hilo_we && !flush && !busy;
  // Not gated by flush: the hazard unit resolves flush priority itself.
  assign stall_req = busy || (hilo_we && is_muldiv(hilo_op));
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_muldiv(hilo_op)) begin
            state_d          = ST_RUN;
            cnt_d            = is_mul(hilo_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            {p_hi_d, p_lo_d} = calc_res;
          end else if (hilo_op == OP_MTHI) begin
            hi_d = rs_data;
          end else if (hilo_op == OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      ST_RUN: begin
        // Result was computed at accept; the countdown only models latency.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_hi_q  <= 32'h0;
      p_lo_q  <= 32'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Testbench for hilo_md_unit: directed vectors, expected {hi,lo} and busy length queued at issue,
// compared by a monitor when busy falls; immediate checks for MTHI/MTLO, flush, no-op and reset.
// Inputs are driven 1ns after the rising edge; the monitor samples on the falling edge.
module tb_hilo_md_unit;
  import hilo_md_unit_pkg::*;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  hilo_op = OP_NOP;
  logic        hilo_we = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] rt_data = 32'h0;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic prev_busy = 1'b0;
  int   busy_cnt = 0;

  hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hilo_op   (hilo_op),
    .hilo_we   (hilo_we),
    .flush     (flush),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a busy 1->0 transition is a completed operation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy) busy_cnt++;
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("result_hilo", {hi, lo}, e.res);
          chk("busy_cycles", 64'(busy_cnt), 64'(e.cyc));
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  // Present a mul/div for one cycle while idle; queue its expected outcome.
  task automatic issue_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res, input int cyc);
    exp_t e;
    e.res = res;
    e.cyc = cyc;
    exp_q.push_back(e);
    hilo_op = op; rs_data = a; rt_data = b; hilo_we = 1'b1; flush = 1'b0;
    #1 chk("stall_req_accept", 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    hilo_we = 1'b0; hilo_op = OP_NOP;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] res, input int cyc);
    issue_md(op, a, b, res, cyc);
    wait_idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_stall", 64'(stall_req), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    md(OP_MULT,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5);
    md(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 5);
    md(OP_DIV,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10);
    md(OP_DIVU,  32'd7,         32'd2, 64'h0000_0001_0000_0003, 10);
    md(OP_DIVU,  32'd5,         32'd0, 64'h0000_0005_FFFF_FFFF, 10);
    md(OP_DIV,   32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, 10);
    md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10);

    // MTHI while idle: single edge, never busy
    hilo_op = OP_MTHI; rs_data = 32'h1234_5678; hilo_we = 1'b1;
    #1 chk("mthi_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    hilo_we = 1'b0; hilo_op = OP_NOP;
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_hilo", {hi, lo}, 64'h1234_5678_8000_0000);

    // unlisted code and explicit no-op leave state alone
    hilo_op = 3'b110; rs_data = 32'hDEAD_BEEF; rt_data = 32'd9; hilo_we = 1'b1;
    @(posedge clk); #1;
    hilo_op = OP_NOP;
    @(posedge clk); #1;
    hilo_we = 1'b0;
    chk("noop_busy", 64'(busy), 64'd0);
    chk("noop_hilo", {hi, lo}, 64'h1234_5678_8000_0000);

    // flushed MULT is not accepted but still requests a stall
    hilo_op = OP_MULT; rs_data = 32'd5; rt_data = 32'd5; hilo_we = 1'b1; flush = 1'b1;
    #1 chk("flush_stall", 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    hilo_we = 1'b0; flush = 1'b0; hilo_op = OP_NOP;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'h1234_5678_8000_0000);

    // MTLO held while busy only lands after the MULT completes
    issue_md(OP_MULT, 32'd2, 32'd3, 64'h0000_0000_0000_0006, 5);
    hilo_op = OP_MTLO; rs_data = 32'hAABB_CCDD; hilo_we = 1'b1;
    #1 chk("stall_while_busy", 64'(stall_req), 64'd1);
    wait_idle();
    chk("mtlo_not_early", 64'(lo), 64'd6);
    @(posedge clk); #1;
    hilo_we = 1'b0; hilo_op = OP_NOP;
    chk("mtlo_after_busy", {hi, lo}, 64'h0000_0000_AABB_CCDD);
    chk("mtlo_busy", 64'(busy), 64'd0);

    // flush during a running DIV does not abort it
    issue_md(OP_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10);
    hilo_op = OP_DIV; rs_data = 32'd1; rt_data = 32'd1; hilo_we = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    hilo_we = 1'b0; flush = 1'b0; hilo_op = OP_NOP;
    chk("flush_mid_div_busy", 64'(busy), 64'd1);
    wait_idle();

    // async reset at cycle 3 of a MULT discards it
    issue_md(OP_MULT, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    md(OP_MULT, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 5);

    repeat (2) @(posedge clk);
    #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
